// File: rtl/bresenham_line_engine.sv
// Bresenham line walker: takes one endpoint pair per start and streams the in-screen
// pixels of the integer line over a valid/ready handshake, one point per advance.
module bresenham_line_engine #(
    parameter int COORD_W = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               done,
    output logic [COORD_W:0]   pix_count
);

    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE_S} state_t;

    state_t state;

    logic [COORD_W-1:0]   x0_r, y0_r, x1_r, y1_r;
    logic signed [EW-1:0] dx, dy, err;
    logic                 sx_neg, sy_neg;

    function automatic logic signed [EW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        logic [COORD_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return signed'({2'b00, d});
    endfunction

    function automatic logic is_visible(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
        return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    endfunction

    logic signed [EW-1:0] dx_w, dy_w, e2, err_nxt;
    logic                 step_x, step_y, at_end, advance;
    logic [COORD_W-1:0]   cx_nxt, cy_nxt;

    // Next-point arithmetic; both axis steps use the same e2, taken before either update
    always_comb begin
        dx_w    = abs_diff(x1_r, x0_r);
        dy_w    = -abs_diff(y1_r, y0_r);
        e2      = err + err;
        step_x  = (e2 >= dy);
        step_y  = (e2 <= dx);
        err_nxt = err + (step_x ? dy : EW'(0)) + (step_y ? dx : EW'(0));
        cx_nxt  = pix_x;
        cy_nxt  = pix_y;
        if (step_x) cx_nxt = sx_neg ? (pix_x - COORD_W'(1)) : (pix_x + COORD_W'(1));
        if (step_y) cy_nxt = sy_neg ? (pix_y - COORD_W'(1)) : (pix_y + COORD_W'(1));
        at_end  = (pix_x == x1_r) && (pix_y == y1_r);
        // Clipped points are not offered downstream, so they advance unconditionally
        advance = (state == DRAW) && (!pix_valid || pix_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        pix_count <= '0;
                    end
                end
                SETUP: begin
                    state     <= DRAW;
                    pix_x     <= x0_r;
                    pix_y     <= y0_r;
                    pix_valid <= is_visible(x0_r, y0_r);
                end
                DRAW: begin
                    if (pix_valid && pix_ready) pix_count <= pix_count + (COORD_W+1)'(1);
                    if (advance) begin
                        if (at_end) begin
                            state     <= DONE_S;
                            pix_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pix_x     <= cx_nxt;
                            pix_y     <= cy_nxt;
                            pix_valid <= is_visible(cx_nxt, cy_nxt);
                        end
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Walk datapath; only meaningful while a line is in flight, so it carries no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            x0_r <= x0;
            y0_r <= y0;
            x1_r <= x1;
            y1_r <= y1;
        end
        if (state == SETUP) begin
            dx     <= dx_w;
            dy     <= dy_w;
            err    <= dx_w + dy_w;
            sx_neg <= (x1_r < x0_r);
            sy_neg <= (y1_r < y0_r);
        end
        if (advance && !at_end) err <= err_nxt;
    end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Bench for bresenham_line_engine: integer line model, directed lines and random
// lines with random back-pressure and ignored start requests while busy.
module tb_bresenham_line_engine;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] x0, y0, x1, y1;
    logic          busy, pix_valid, pix_ready, done;
    logic [CW-1:0] pix_x, pix_y;
    logic [CW:0]   pix_count;

    int errors = 0;
    int checks = 0;

    typedef struct {int x; int y;} pt_t;
    pt_t all_pts[$];
    pt_t vis_pts[$];

    bresenham_line_engine #(.COORD_W(CW), .H_RES(640), .V_RES(480)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .done(done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference walk: full point list plus the on-screen subset
    task automatic model_line(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        all_pts.delete();
        vis_pts.delete();
        dx = (bx > ax) ? bx - ax : ax - bx;
        dy = -((by > ay) ? by - ay : ay - by);
        sx = (bx >= ax) ? 1 : -1;
        sy = (by >= ay) ? 1 : -1;
        err = dx + dy;
        x = ax;
        y = ay;
        for (int k = 0; k < 5000; k++) begin
            all_pts.push_back('{x, y});
            if (x < 640 && y < 480) vis_pts.push_back('{x, y});
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready + stray starts
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input int mode, output int done_k, output int cnt);
        int idx, stalls, streak, bound, p;
        logic rdy;
        model_line(ax, ay, bx, by);
        bound = 20 + 8 * all_pts.size();
        @(negedge clk);
        x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_in_setup", pix_valid, 0);
        idx = 0; stalls = 0; streak = 0; done_k = -1; cnt = -1; p = 0;
        for (int k = 2; k < bound; k++) begin
            @(negedge clk);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (p % 3 == 0);
                default: rdy = ($urandom_range(0, 9) < 7) || (streak >= 4);
            endcase
            p++;
            pix_ready = rdy;
            if (done) begin
                start = 1'b0;
                done_k = k;
                cnt = int'(pix_count);
                chk("count_at_done", pix_count, vis_pts.size());
                chk("pixels_consumed", idx, vis_pts.size());
                chk("valid_at_done", pix_valid, 0);
                chk("busy_at_done", busy, 1);
                break;
            end
            if (pix_valid) begin
                if (idx < vis_pts.size()) begin
                    chk("pix_x", pix_x, vis_pts[idx].x);
                    chk("pix_y", pix_y, vis_pts[idx].y);
                end else begin
                    chk("extra_pixel", idx, vis_pts.size() - 1);
                end
                if (rdy) begin idx++; streak = 0; end
                else begin stalls++; streak++; end
            end
            if (mode == 2 && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_k < 0) chk("done_timeout", 0, 1);
        chk("done_cycle", done_k, 2 + all_pts.size() + stalls);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    int dk, cnt, ax, ay, bx, by;
    bit saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_count", pix_count, 0);
        rst = 1'b0;

        // Pin the reference walk with hand-derived sequences
        model_line(0, 0, 4, 2);
        chk("model_fwd_len", all_pts.size(), 5);
        chk("model_fwd_p1", all_pts[1].x * 100 + all_pts[1].y, 101);
        chk("model_fwd_p2", all_pts[2].x * 100 + all_pts[2].y, 201);
        chk("model_fwd_p3", all_pts[3].x * 100 + all_pts[3].y, 302);
        model_line(4, 2, 0, 0);
        chk("model_rev_p1", all_pts[1].x * 100 + all_pts[1].y, 301);
        chk("model_rev_p3", all_pts[3].x * 100 + all_pts[3].y, 100);
        model_line(638, 0, 642, 0);
        chk("model_clip_vis", vis_pts.size(), 2);

        run_line(0, 0, 3, 0, 0, dk, cnt);
        chk("t1_done_cycle", dk, 6);
        chk("t1_count", cnt, 4);
        run_line(5, 5, 5, 5, 0, dk, cnt);
        chk("t2_done_cycle", dk, 3);
        chk("t2_count", cnt, 1);
        run_line(0, 0, 4, 2, 0, dk, cnt);
        chk("t3_count", cnt, 5);
        run_line(4, 2, 0, 0, 0, dk, cnt);
        chk("t3r_count", cnt, 5);
        run_line(2, 2, 2, 6, 1, dk, cnt);
        chk("t4_count", cnt, 5);
        run_line(638, 0, 642, 0, 0, dk, cnt);
        chk("t5_done_cycle", dk, 7);
        chk("t5_count", cnt, 2);
        run_line(700, 500, 710, 505, 2, dk, cnt);
        chk("offscreen_count", cnt, 0);

        // Asynchronous reset in the middle of a long line
        @(negedge clk);
        x0 = 0; y0 = 0; x1 = 100; y1 = 100; start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t6_mid_valid", pix_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_valid", pix_valid, 0);
        chk("t6_pix_x", pix_x, 0);
        chk("t6_pix_y", pix_y, 0);
        chk("t6_count", pix_count, 0);
        chk("t6_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t6_no_done", saw_done, 0);
        run_line(1, 1, 2, 2, 0, dk, cnt);
        chk("t6_new_done_cycle", dk, 4);
        chk("t6_new_count", cnt, 2);

        for (int n = 0; n < 40; n++) begin
            ax = $urandom_range(0, 1023);
            ay = $urandom_range(0, 1023);
            if (n % 8 == 7) begin
                bx = $urandom_range(0, 1023);
                by = $urandom_range(0, 1023);
            end else begin
                bx = ax + $urandom_range(0, 60) - 30;
                by = ay + $urandom_range(0, 60) - 30;
                if (bx < 0) bx = 0;
                if (bx > 1023) bx = 1023;
                if (by < 0) by = 0;
                if (by > 1023) by = 1023;
            end
            run_line(ax, ay, bx, by, 2, dk, cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
